// File: rtl/mcycle_pkg.sv
// Shared encodings, FSM state type and default width for the multi-cycle mul/div unit.
package mcycle_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MUL    = 1'b0;
  localparam logic OP_DIV    = 1'b1;
  localparam int   OP_SIGNED = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTING = 2'd1,
    DONE      = 2'd2
  } state_t;

endpackage

// File: rtl/mcycle_iter_dp.sv
// One shift-add (MUL) or restoring shift-subtract (DIV) step over the {hi,lo} pair.
module mcycle_iter_dp
  import mcycle_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;

  always_comb begin
    mul_sum = {1'b0, hi};
    if (lo[0]) mul_sum = {1'b0, hi} + {1'b0, opnd};

    // Remainder stays below the divisor, so the true difference always fits WIDTH bits
    rem_sh   = {hi, lo[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd});
    rem_diff = rem_sh[WIDTH-1:0] - opnd;

    if (op == OP_MUL) begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_nxt = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], rem_ge};
    end
  end

endmodule

// File: rtl/mcycle_seq.sv
// Iterative multiply/divide sequencer: WIDTH iterations per op, Busy stalls the pipe.
// Optional signed mode enabled by defining MCYCLE_SIGNED_EN.
//
// state     | meaning
// IDLE      | waiting for Start
// COMPUTING | one datapath iteration per cycle, count 0..WIDTH-1
// DONE      | results just captured, Done pulse; Start here chains a new op
module mcycle_seq
  import mcycle_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi, lo, opnd;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] res1, res2;
  logic             op_div;
  logic             accept, last;

  assign accept = Start && (state != COMPUTING);
  assign last   = (state == COMPUTING) && (count == CW'(WIDTH - 1));
  assign Busy   = accept || (state == COMPUTING);

  mcycle_iter_dp #(.WIDTH(WIDTH)) u_iter_dp (
    .op     (op_div),
    .hi     (hi),
    .lo     (lo),
    .opnd   (opnd),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

`ifdef MCYCLE_SIGNED_EN
  logic sign1, sign2;
  logic neg_q, neg_r, div0;

  assign sign1 = MCycleOp[OP_SIGNED] & Operand1[WIDTH-1];
  assign sign2 = MCycleOp[OP_SIGNED] & Operand2[WIDTH-1];
  assign mag1  = sign1 ? -Operand1 : Operand1;
  assign mag2  = sign2 ? -Operand2 : Operand2;

  // Sign fix-up sits in front of the result registers, so it costs no extra cycle
  always_comb begin
    res1 = lo_nxt;
    res2 = hi_nxt;
    if (neg_q) begin
      if (!op_div)    {res2, res1} = -{hi_nxt, lo_nxt};
      else if (!div0) res1 = -lo_nxt;
    end
    if (op_div && neg_r) res2 = -hi_nxt;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else if (accept) begin
      neg_q <= sign1 ^ sign2;
      neg_r <= sign1;
      div0  <= (Operand2 == '0);
    end
  end
`else
  logic unused_signed;

  assign unused_signed = MCycleOp[OP_SIGNED];
  assign mag1          = Operand1;
  assign mag2          = Operand2;
  assign res1          = lo_nxt;
  assign res2          = hi_nxt;
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
      op_div  <= 1'b0;
      Result1 <= '0;
      Result2 <= '0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_div <= MCycleOp[0];
            count  <= '0;
            hi     <= '0;
            // MUL shifts the multiplier through lo; DIV shifts the dividend out of lo
            lo     <= (MCycleOp[0] == OP_DIV) ? mag1 : mag2;
            opnd   <= (MCycleOp[0] == OP_DIV) ? mag2 : mag1;
            state  <= COMPUTING;
          end else begin
            state <= IDLE;
          end
        end
        COMPUTING: begin
          hi    <= hi_nxt;
          lo    <= lo_nxt;
          count <= count + CW'(1);
          if (last) begin
            Result1 <= res1;
            Result2 <= res2;
            Done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
